// File: rtl/vga_pkg.sv
// Timing-set definitions shared by the VGA timing generator and its axis counters.
// Pure types and constants: no latency, no flow control.
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_pulse;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_pulse;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_pulse: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_pulse: 16'd2,   v_bp: 16'd33,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam vga_timing_t VGA_800X600 = '{
        h_active: 16'd800, h_fp: 16'd40, h_pulse: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_pulse: 16'd4,   v_bp: 16'd23,
        h_pol: 1'b1, v_pol: 1'b1};

    localparam vga_timing_t TB_TINY = '{
        h_active: 16'd8, h_fp: 16'd2, h_pulse: 16'd3, h_bp: 16'd1,
        v_active: 16'd4, v_fp: 16'd1, v_pulse: 16'd1, v_bp: 16'd1,
        h_pol: 1'b0, v_pol: 1'b1};

    function automatic int unsigned h_period(input vga_timing_t t);
        return int'(t.h_active) + int'(t.h_fp) + int'(t.h_pulse) + int'(t.h_bp);
    endfunction

    function automatic int unsigned v_period(input vga_timing_t t);
        return int'(t.v_active) + int'(t.v_fp) + int'(t.v_pulse) + int'(t.v_bp);
    endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One scan axis: position counter with wrap, plus combinational sync/active decode of the count.
// Counter advances one position per step; no backpressure, step simply gates the advance.
module vga_axis_ctr #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic [W-1:0] active,
    input  logic [W-1:0] fp,
    input  logic [W-1:0] pulse,
    input  logic [W-1:0] bp,
    input  logic         pol,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync,
    output logic         act
);

    logic [W-1:0] sync_lo;
    logic [W-1:0] sync_hi;
    logic [W-1:0] last;

    assign sync_lo = active + fp;
    assign sync_hi = sync_lo + pulse;
    assign last    = sync_hi + bp - W'(1);

    assign wrap = (cnt == last);
    assign act  = (cnt < active);
    assign sync = ((cnt >= sync_lo) && (cnt < sync_hi)) ? pol : ~pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Dual-mode VGA raster timing generator; outputs are registered one pixel tick after the counts they decode.
// en=0 freezes everything; mode changes only take effect at a frame boundary.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          H_BITS   = 11,
    parameter int          V_BITS   = 10,
    parameter vga_timing_t TIMING_A = vga_pkg::VGA_640X480,
    parameter vga_timing_t TIMING_B = vga_pkg::VGA_800X600,
    parameter int          PIX_DIV  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode_sel,
    output logic              mode_act,
    output logic              pix_tick,
    output logic              h_sync,
    output logic              v_sync,
    output logic              disp_ena,
    output logic              n_blank,
    output logic              n_sync,
    output logic [H_BITS-1:0] col,
    output logic [V_BITS-1:0] row,
    output logic              line_start,
    output logic              frame_start
);

    localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $fatal(1, "vga_timing_gen: PIX_DIV outside 1..16");
    end
    if (H_BITS > 16 || V_BITS > 16) begin : g_bad_bits
        $fatal(1, "vga_timing_gen: axis width exceeds timing field width");
    end
    if (int'(TIMING_A.h_active) > (2**H_BITS) - 1 || int'(TIMING_B.h_active) > (2**H_BITS) - 1 ||
        h_period(TIMING_A) > (2**H_BITS) || h_period(TIMING_B) > (2**H_BITS)) begin : g_bad_h
        $fatal(1, "vga_timing_gen: horizontal timing does not fit H_BITS");
    end
    if (int'(TIMING_A.v_active) > (2**V_BITS) - 1 || int'(TIMING_B.v_active) > (2**V_BITS) - 1 ||
        v_period(TIMING_A) > (2**V_BITS) || v_period(TIMING_B) > (2**V_BITS)) begin : g_bad_v
        $fatal(1, "vga_timing_gen: vertical timing does not fit V_BITS");
    end

    logic [PW-1:0]     pre;
    logic              tick;
    logic              mode_cur;
    logic [H_BITS-1:0] h_cnt;
    logic [V_BITS-1:0] v_cnt;
    logic              h_wrap, v_wrap, h_sync_d, v_sync_d, h_act, v_act;

    assign tick     = en && (pre == PW'(PIX_DIV - 1));
    assign pix_tick = tick && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // mode_cur drives the counters; mode_act is its registered, display-aligned copy.
    vga_axis_ctr #(.W(H_BITS)) u_h (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (tick),
        .active(mode_cur ? TIMING_B.h_active[H_BITS-1:0] : TIMING_A.h_active[H_BITS-1:0]),
        .fp    (mode_cur ? TIMING_B.h_fp[H_BITS-1:0]     : TIMING_A.h_fp[H_BITS-1:0]),
        .pulse (mode_cur ? TIMING_B.h_pulse[H_BITS-1:0]  : TIMING_A.h_pulse[H_BITS-1:0]),
        .bp    (mode_cur ? TIMING_B.h_bp[H_BITS-1:0]     : TIMING_A.h_bp[H_BITS-1:0]),
        .pol   (mode_cur ? TIMING_B.h_pol : TIMING_A.h_pol),
        .cnt   (h_cnt),
        .wrap  (h_wrap),
        .sync  (h_sync_d),
        .act   (h_act)
    );

    vga_axis_ctr #(.W(V_BITS)) u_v (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (tick && h_wrap),
        .active(mode_cur ? TIMING_B.v_active[V_BITS-1:0] : TIMING_A.v_active[V_BITS-1:0]),
        .fp    (mode_cur ? TIMING_B.v_fp[V_BITS-1:0]     : TIMING_A.v_fp[V_BITS-1:0]),
        .pulse (mode_cur ? TIMING_B.v_pulse[V_BITS-1:0]  : TIMING_A.v_pulse[V_BITS-1:0]),
        .bp    (mode_cur ? TIMING_B.v_bp[V_BITS-1:0]     : TIMING_A.v_bp[V_BITS-1:0]),
        .pol   (mode_cur ? TIMING_B.v_pol : TIMING_A.v_pol),
        .cnt   (v_cnt),
        .wrap  (v_wrap),
        .sync  (v_sync_d),
        .act   (v_act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_cur    <= 1'b0;
            mode_act    <= 1'b0;
            h_sync      <= ~TIMING_A.h_pol;
            v_sync      <= ~TIMING_A.v_pol;
            disp_ena    <= 1'b0;
            col         <= '0;
            row         <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick) begin
            if (h_wrap && v_wrap) begin
                mode_cur <= mode_sel;
            end
            mode_act    <= mode_cur;
            h_sync      <= h_sync_d;
            v_sync      <= v_sync_d;
            disp_ena    <= h_act && v_act;
            if (h_act) col <= h_cnt;
            if (v_act) row <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign n_blank = disp_ena;
    assign n_sync  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (PIX_DIV 1 and 3) checked every cycle against a pixel-index model,
// plus literal frame/line measurements, a mode switch, an enable drop and a mid-frame async reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam vga_timing_t TB_ALT = '{
        h_active: 16'd6, h_fp: 16'd1, h_pulse: 16'd2, h_bp: 16'd1,
        v_active: 16'd3, v_fp: 16'd1, v_pulse: 16'd1, v_bp: 16'd1,
        h_pol: 1'b1, v_pol: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  en = 2'b11;
    logic [1:0]  mode_sel = 2'b00;
    logic [1:0]  mode_act, pix_tick, h_sync, v_sync, disp_ena, n_blank, n_sync, line_start, frame_start;
    logic [10:0] col0, col1;
    logic [9:0]  row0, row1;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_BITS(11), .V_BITS(10), .TIMING_A(TB_TINY), .TIMING_B(TB_ALT), .PIX_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .mode_sel(mode_sel[0]), .mode_act(mode_act[0]),
        .pix_tick(pix_tick[0]), .h_sync(h_sync[0]), .v_sync(v_sync[0]), .disp_ena(disp_ena[0]),
        .n_blank(n_blank[0]), .n_sync(n_sync[0]), .col(col0), .row(row0),
        .line_start(line_start[0]), .frame_start(frame_start[0]));

    vga_timing_gen #(.H_BITS(11), .V_BITS(10), .TIMING_A(TB_TINY), .TIMING_B(TB_ALT), .PIX_DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .mode_sel(mode_sel[1]), .mode_act(mode_act[1]),
        .pix_tick(pix_tick[1]), .h_sync(h_sync[1]), .v_sync(v_sync[1]), .disp_ena(disp_ena[1]),
        .n_blank(n_blank[1]), .n_sync(n_sync[1]), .col(col1), .row(row1),
        .line_start(line_start[1]), .frame_start(frame_start[1]));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pdiv(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic vga_timing_t tset(input bit m);
        return m ? TB_ALT : TB_TINY;
    endfunction

    // Model: pixel index within the frame, updated once per modelled pixel tick.
    int m_p[2], m_ec[2];
    bit m_mode[2];
    bit e_hs[2], e_vs[2], e_de[2], e_ls[2], e_fs[2], e_ma[2];
    int e_col[2], e_row[2];

    task automatic model_tick(input int d);
        vga_timing_t t;
        int hper, vper, h, v, ha, va, hs0, vs0;
        t    = tset(m_mode[d]);
        ha   = int'(t.h_active);
        va   = int'(t.v_active);
        hs0  = ha + int'(t.h_fp);
        vs0  = va + int'(t.v_fp);
        hper = hs0 + int'(t.h_pulse) + int'(t.h_bp);
        vper = vs0 + int'(t.v_pulse) + int'(t.v_bp);
        h = m_p[d] % hper;
        v = m_p[d] / hper;
        e_de[d] = (h < ha) && (v < va);
        if (h < ha) e_col[d] = h;
        if (v < va) e_row[d] = v;
        e_hs[d] = (h >= hs0 && h < hs0 + int'(t.h_pulse)) ? t.h_pol : !t.h_pol;
        e_vs[d] = (v >= vs0 && v < vs0 + int'(t.v_pulse)) ? t.v_pol : !t.v_pol;
        e_ls[d] = (h == 0);
        e_fs[d] = (m_p[d] == 0);
        e_ma[d] = m_mode[d];
        m_p[d]++;
        if (m_p[d] == hper * vper) begin
            m_p[d] = 0;
            m_mode[d] = mode_sel[d];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_p[d] = 0; m_ec[d] = 0; m_mode[d] = 1'b0;
                e_hs[d] = !TB_TINY.h_pol; e_vs[d] = !TB_TINY.v_pol;
                e_de[d] = 1'b0; e_ls[d] = 1'b0; e_fs[d] = 1'b0; e_ma[d] = 1'b0;
                e_col[d] = 0; e_row[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (en[d]) begin
                    if (m_ec[d] % pdiv(d) == pdiv(d) - 1) model_tick(d);
                    m_ec[d]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("pix_tick%0d", d), pix_tick[d],
                    rst_n && en[d] && (m_ec[d] % pdiv(d) == pdiv(d) - 1));
                chk($sformatf("h_sync%0d", d), h_sync[d], e_hs[d]);
                chk($sformatf("v_sync%0d", d), v_sync[d], e_vs[d]);
                chk($sformatf("disp_ena%0d", d), disp_ena[d], e_de[d]);
                chk($sformatf("n_blank%0d", d), n_blank[d], e_de[d]);
                chk($sformatf("n_sync%0d", d), n_sync[d], 0);
                chk($sformatf("line_start%0d", d), line_start[d], e_ls[d]);
                chk($sformatf("frame_start%0d", d), frame_start[d], e_fs[d]);
                chk($sformatf("mode_act%0d", d), mode_act[d], e_ma[d]);
                chk($sformatf("col%0d", d), (d == 0) ? int'(col0) : int'(col1), e_col[d]);
                chk($sformatf("row%0d", d), (d == 0) ? int'(row0) : int'(row1), e_row[d]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input int d, output int n);
        bit prev, found;
        prev = frame_start[d];
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            cyc();
            n++;
            if (frame_start[d] && !prev) found = 1'b1;
            prev = frame_start[d];
        end
        if (!found) begin
            chk($sformatf("frame_start%0d_timeout", d), 0, 1);
            n = -1;
        end
    endtask

    task automatic reset_checks(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_h_sync"}, h_sync[d], 1);
            chk({tag, "_v_sync"}, v_sync[d], 0);
            chk({tag, "_disp_ena"}, disp_ena[d], 0);
            chk({tag, "_n_blank"}, n_blank[d], 0);
            chk({tag, "_pix_tick"}, pix_tick[d], 0);
            chk({tag, "_line_start"}, line_start[d], 0);
            chk({tag, "_frame_start"}, frame_start[d], 0);
            chk({tag, "_mode_act"}, mode_act[d], 0);
        end
        chk({tag, "_col"}, {col1, col0}, 0);
        chk({tag, "_row"}, {row1, row0}, 0);
    endtask

    initial begin
        int nde, nls, nfs, nvs, hs_err, col_err, n;
        bit early, found;

        #12;
        reset_checks("reset");
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        cyc();
        chk("first_frame_start", frame_start[0], 1);
        chk("first_line_start", line_start[0], 1);
        chk("first_disp_ena", disp_ena[0], 1);
        chk("first_col", col0, 0);
        chk("first_row", row0, 0);

        nde = 0; nls = 0; nfs = 0; nvs = 0; hs_err = 0; col_err = 0;
        for (int i = 0; i < 98; i++) begin
            if (disp_ena[0]) nde++;
            if (line_start[0]) nls++;
            if (frame_start[0]) nfs++;
            if (v_sync[0]) nvs++;
            if (h_sync[0] != !((i % 14) >= 10 && (i % 14) < 13)) hs_err++;
            if (i < 14 && int'(col0) != ((i < 8) ? i : 7)) col_err++;
            if (i == 97) begin
                chk("held_col", col0, 7);
                chk("held_row", row0, 3);
            end
            cyc();
        end
        chk("frame_disp_ticks", nde, 32);
        chk("frame_line_starts", nls, 7);
        chk("frame_starts_in_frame", nfs, 1);
        chk("frame_vsync_ticks", nvs, 14);
        chk("hsync_pattern_errors", hs_err, 0);
        chk("col_sequence_errors", col_err, 0);
        chk("frame_period_98", frame_start[0], 1);

        wait_fs(1, n);
        wait_fs(1, n);
        chk("frame_clks_div3", n, 294);

        wait_fs(0, n);
        repeat (20) cyc();
        mode_sel[0] = 1'b1;
        early = 1'b0; found = 1'b0; n = 0;
        while (!found && n < 200) begin
            cyc();
            n++;
            if (frame_start[0]) found = 1'b1;
            else if (mode_act[0]) early = 1'b1;
        end
        chk("mode_switch_seen", found, 1);
        chk("mode_act_early", early, 0);
        chk("mode_act_at_frame", mode_act[0], 1);
        wait_fs(0, n);
        chk("frame_period_mode_b", n, 60);
        mode_sel[0] = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 2; d++) begin
                en[d] = ($urandom_range(0, 99) < 85);
                if ($urandom_range(0, 199) == 0) mode_sel[d] = ~mode_sel[d];
            end
            cyc();
        end

        en = 2'b11;
        repeat (30) cyc();
        en = 2'b00;
        repeat (5) cyc();
        en = 2'b11;
        repeat (7) cyc();
        #3 rst_n = 1'b0;
        #1;
        reset_checks("midframe_reset");
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_BITS, default 11: horizontal counter and col width.
REQ-002 The block SHALL have parameter V_BITS, default 10: vertical counter and row width.
REQ-003 The block SHALL have parameter TIMING_A, default vga_pkg::VGA_640X480: timing set for mode 0.
REQ-004 The block SHALL have parameter TIMING_B, default vga_pkg::VGA_800X600: timing set for mode 1.
REQ-005 The block SHALL have parameter PIX_DIV, default 1, legal range 1..16: system clocks per pixel tick.
REQ-006 The block SHALL have port clk, input, width 1: single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-008 The block SHALL have port en, input, width 1: run enable; low freezes the prescaler and counters.
REQ-009 The block SHALL have port mode_sel, input, width 1: requested timing set (0 = A, 1 = B).
REQ-010 The block SHALL have port mode_act, output, width 1: timing set currently in use.
REQ-011 The block SHALL have port pix_tick, output, width 1: one-clock strobe each pixel period.
REQ-012 The block SHALL have port h_sync and v_sync, outputs, width 1 each: syncs at the active timing set's polarity.
REQ-013 The block SHALL have port disp_ena, output, width 1: high while inside the active pixel area.
REQ-014 The block SHALL have ports n_blank and n_sync, outputs, width 1 each: n_blank = disp_ena; n_sync is constant 0.
REQ-015 The block SHALL have ports col (width H_BITS) and row (width V_BITS), outputs: current pixel coordinate, held outside the active area.
REQ-016 The block SHALL have ports line_start and frame_start, outputs, width 1 each: one-tick strobes at h_cnt==0 and at h_cnt==0 && v_cnt==0.

Function
REQ-017 Each timing set SHALL hold active, fp, pulse, bp (per axis) and h_pol, v_pol; period = active+fp+pulse+bp.
REQ-018 The prescaler SHALL count 0..PIX_DIV-1 while en=1 and assert pix_tick on the clock where it equals PIX_DIV-1; with PIX_DIV=1, pix_tick = en.
REQ-019 On a pix_tick, h_cnt SHALL increment; at h_period-1 it SHALL wrap to 0 and increment v_cnt, which wraps to 0 at v_period-1.
REQ-020 All outputs SHALL be registered and updated only on a pix_tick, decoded from the counter values before that tick (1-tick latency).
REQ-021 h_sync SHALL equal h_pol when active+fp <= h_cnt < active+fp+pulse, else ~h_pol; v_sync SHALL follow the same rule on v_cnt.
REQ-022 disp_ena SHALL be 1 iff h_cnt < h_active and v_cnt < v_active; col and row SHALL load only while their own axis is active.
REQ-023 mode_sel SHALL be sampled only on the tick where both counters wrap to 0; mode_act changes there, so no partial frame uses a mixed timing set.
REQ-024 If an active count exceeds 2**H_BITS-1 or 2**V_BITS-1, elaboration SHALL fail via an assertion.
REQ-025 With en=0, all state and outputs SHALL hold and pix_tick SHALL be 0; en=1 resumes with no skipped or repeated count.

Reset
REQ-026 While rst_n=0 (asynchronous assert, synchronous release), counters, prescaler, col, row, disp_ena, n_blank, pix_tick, line_start and frame_start SHALL be 0.
REQ-027 During reset, h_sync and v_sync SHALL be the inactive level (~pol) of TIMING_A, and mode_act SHALL be 0.
REQ-028 The first pix_tick after release SHALL produce frame_start=1, line_start=1 and disp_ena=1 with col=0 and row=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame immediately; no pending mode switch SHALL be retained.

Structure
REQ-030 Package vga_pkg SHALL hold the vga_timing_t struct typedef and the named constants VGA_640X480, VGA_800X600 and TB_TINY.
REQ-031 One sub-module, vga_axis_ctr, SHALL implement a single axis (counter, wrap, sync decode, active flag) and be instantiated twice.

Verification
REQ-032 Reset with TB_TINY (h 8/2/3/1, v 4/1/1/1, pol 0/1), PIX_DIV=1 -> line period 14, frame 98 ticks, h_sync low for 3 ticks starting at the 11th tick of each line.
REQ-033 Scan one frame -> disp_ena high for 32 ticks, col 0..7 then held at 7, row 0..3 then held at 3.
REQ-034 PIX_DIV=3 -> pix_tick every 3rd clock; all outputs change only on ticks; frame = 294 clocks.
REQ-035 Toggle mode_sel mid-frame -> mode_act and timing change exactly at the next frame_start, not before.
REQ-036 Drop en for 5 clocks mid-line, then reset mid-frame -> counters hold, then all outputs return to their REQ-026/027 values asynchronously.
